// File: rtl/cmac_aes128_ctrl.sv
// rtl/cmac_aes128_ctrl.sv - AES-CMAC mode controller driving an iterative AES-128 core
module cmac_aes128_ctrl #(
  parameter int AES_LAT = 44
) (
  input  logic         CLK,
  input  logic         Rst,
  input  logic         key_ld,
  input  logic [127:0] key_in,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [127:0] msg_data,
  input  logic         msg_last,
  input  logic [4:0]   msg_bytes,
  output logic         tag_valid,
  output logic [127:0] tag,
  output logic         busy,
  output logic         aes_ld,
  output logic [127:0] aes_key,
  output logic [127:0] aes_text,
  input  logic [127:0] aes_out
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SUBKEY   = 3'd1,
    WAIT_MSG = 3'd2,
    ENC      = 3'd3,
    TAG      = 3'd4
  } state_t;

  localparam logic [7:0] LAT = 8'(AES_LAT);

  state_t       state, state_d;
  logic [127:0] k1_q, k2_q, x_q;
  logic [127:0] k1_d, k2_d;
  logic [127:0] padded, y_d;
  logic [4:0]   n_bytes;
  logic [7:0]   cnt_q;
  logic         last_q;
  logic         accept, launch, core_done;

  // GF(2^128) doubling used for subkey derivation
  function automatic logic [127:0] dbl(input logic [127:0] v);
    dbl = {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
  endfunction

  assign k1_d      = dbl(aes_out);
  assign k2_d      = dbl(k1_d);
  assign core_done = (cnt_q == LAT);
  assign busy      = (state == SUBKEY) || (state == ENC) || (state == TAG);

  // State register
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state, handshake and core launch; key_ld overrides everything
  always_comb begin
    state_d   = state;
    launch    = 1'b0;
    accept    = 1'b0;
    msg_ready = 1'b0;
    case (state)
      IDLE:     ;
      SUBKEY:   if (core_done) state_d = WAIT_MSG;
      WAIT_MSG: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          accept  = 1'b1;
          launch  = 1'b1;
          state_d = ENC;
        end
      end
      ENC:      if (core_done) state_d = last_q ? TAG : WAIT_MSG;
      TAG:      state_d = WAIT_MSG;
      default:  state_d = IDLE;
    endcase
    if (key_ld) begin
      state_d   = SUBKEY;
      launch    = 1'b1;
      accept    = 1'b0;
      msg_ready = 1'b0;
    end
  end

  // Final-block padding and chaining XOR feeding the core
  always_comb begin
    n_bytes = (msg_bytes > 5'd16) ? 5'd16 : msg_bytes;
    padded  = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < n_bytes)       padded[127-8*i -: 8] = msg_data[127-8*i -: 8];
      else if (5'(i) == n_bytes) padded[127-8*i -: 8] = 8'h80;
    end
    if (!msg_last)             y_d = x_q ^ msg_data;
    else if (n_bytes == 5'd16) y_d = x_q ^ msg_data ^ k1_q;
    else                       y_d = x_q ^ padded ^ k2_q;
  end

  // Datapath: key/text to core, latency counter, subkeys, chain and tag
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      aes_ld    <= 1'b0;
      aes_key   <= '0;
      aes_text  <= '0;
      tag       <= '0;
      tag_valid <= 1'b0;
      k1_q      <= '0;
      k2_q      <= '0;
      x_q       <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      aes_ld    <= launch;
      tag_valid <= 1'b0;
      if (launch)              cnt_q <= '0;
      else if (cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
      if (key_ld) begin
        aes_key  <= key_in;
        aes_text <= '0;
        x_q      <= '0;
        last_q   <= 1'b0;
      end else begin
        case (state)
          SUBKEY: if (core_done) begin
            k1_q <= k1_d;
            k2_q <= k2_d;
            x_q  <= '0;
          end
          WAIT_MSG: if (accept) begin
            aes_text <= y_d;
            last_q   <= msg_last;
          end
          ENC: if (core_done) begin
            x_q <= aes_out;
            if (last_q) begin
              tag       <= aes_out;
              tag_valid <= 1'b1;
            end
          end
          TAG:     x_q <= '0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmac_aes128_ctrl.sv
// tb/tb_cmac_aes128_ctrl.sv - directed vector bench for cmac_aes128_ctrl with AES-128 core model
`timescale 1ns/1ps
module tb_cmac_aes128_ctrl;

  localparam int AES_LAT = 44;
  localparam int LIM     = 4*AES_LAT + 20;

  logic         CLK = 1'b0;
  logic         Rst = 1'b1;
  logic         key_ld = 1'b0;
  logic [127:0] key_in = '0;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [127:0] msg_data = '0;
  logic         msg_last = 1'b0;
  logic [4:0]   msg_bytes = '0;
  logic         tag_valid;
  logic [127:0] tag;
  logic         busy;
  logic         aes_ld;
  logic [127:0] aes_key;
  logic [127:0] aes_text;
  logic [127:0] aes_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  cmac_aes128_ctrl #(.AES_LAT(AES_LAT)) dut (
    .CLK(CLK), .Rst(Rst), .key_ld(key_ld), .key_in(key_in),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_last(msg_last), .msg_bytes(msg_bytes), .tag_valid(tag_valid),
    .tag(tag), .busy(busy), .aes_ld(aes_ld), .aes_key(aes_key),
    .aes_text(aes_text), .aes_out(aes_out)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    xt = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    gmul = p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int k);
    rol8 = (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] rk, s, o;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  t;
    rk = k; rc = 8'h01;
    s = p ^ rk;
    for (int r = 1; r <= 10; r++) begin
      t = rk[31:0];
      t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      rk[127:96] = rk[127:96] ^ t;
      rk[95:64]  = rk[95:64]  ^ rk[127:96];
      rk[63:32]  = rk[63:32]  ^ rk[95:64];
      rk[31:0]   = rk[31:0]   ^ rk[63:32];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          o[127-8*(rr+4*c) -: 8] = s[127-8*(rr+4*((c+rr)%4)) -: 8];
      s = o;
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
          s[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = s ^ rk;
    end
    aes_enc = s;
  endfunction

  // ---------------- fixed-latency core model ----------------
  logic [127:0] m_key, m_txt, m_res;
  int           m_cnt = 0;

  // Capture on load; result is visible only in the cycle the controller should sample
  always @(posedge CLK or posedge Rst) begin
    if (Rst) m_cnt <= 0;
    else if (aes_ld) begin
      m_key <= aes_key;
      m_txt <= aes_text;
      m_res <= aes_enc(aes_key, aes_text);
      m_cnt <= 1;
    end else if (m_cnt != 0 && m_cnt <= AES_LAT) m_cnt <= m_cnt + 1;
  end

  assign aes_out = (m_cnt == AES_LAT) ? m_res : ~m_res;

  // Core inputs must be unchanged at the capture cycle
  always @(negedge CLK) begin
    if (!Rst && m_cnt == AES_LAT) begin
      chk("core_key_stable", aes_key, m_key);
      chk("core_text_stable", aes_text, m_txt);
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    int           nblk;
    logic [511:0] data;
    logic [4:0]   nbytes;
    int           gap;
    logic [127:0] exp_tag;
  } msg_vec_t;

  msg_vec_t vecs [4];

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B0  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] B1  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] B2  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] B3  = 128'hf69f2445df4f9b17ad2b417be66c3710;

  task automatic wait_ready(output int waited);
    waited = 0;
    while (!msg_ready && waited < LIM) begin
      @(negedge CLK);
      waited++;
    end
  endtask

  task automatic load_key(input logic [127:0] k, input string name);
    int t0, w;
    key_in = k; key_ld = 1'b1; t0 = cyc;
    @(negedge CLK);
    key_ld = 1'b0;
    wait_ready(w);
    chk(name, 128'(cyc - t0), 128'(AES_LAT + 2));
  endtask

  task automatic send_msg(input msg_vec_t v, input string name);
    int acc, w;
    for (int b = 0; b < v.nblk; b++) begin
      repeat (v.gap) @(negedge CLK);
      msg_data  = v.data[511-128*b -: 128];
      msg_last  = (b == v.nblk - 1);
      msg_bytes = msg_last ? v.nbytes : 5'd3;
      msg_valid = 1'b1;
      wait_ready(w);
      acc = cyc;
      @(negedge CLK);
      msg_valid = 1'b0;
      msg_data  = {4{$urandom}};
      msg_last  = 1'b0;
      w = 0;
      if (b == v.nblk - 1) begin
        while (!tag_valid && w < LIM) begin @(negedge CLK); w++; end
        chk({name, "_tag_lat"}, 128'(cyc - acc), 128'(AES_LAT + 2));
        chk({name, "_tag"}, tag, v.exp_tag);
        @(negedge CLK);
        chk({name, "_after_tag"}, {126'h0, tag_valid, msg_ready}, 128'h1);
      end else begin
        while (!msg_ready && w < LIM) begin @(negedge CLK); w++; end
        chk({name, "_blk_ready_lat"}, 128'(cyc - acc), 128'(AES_LAT + 2));
      end
    end
  endtask

  initial begin
    int w, t0;
    bit saw_tag, saw_ready;
    logic [127:0] prev_tag;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ rol8(b, 1) ^ rol8(b, 2) ^ rol8(b, 3) ^ rol8(b, 4) ^ 8'h63;
    end

    vecs[0] = '{nblk: 1, data: {128'hffffffffffffffffffffffffffffffff, 384'h0},
                nbytes: 5'd0, gap: 0, exp_tag: 128'hbb1d6929e95937287fa37d129b756746};
    vecs[1] = '{nblk: 1, data: {B0, 384'h0},
                nbytes: 5'd16, gap: 1, exp_tag: 128'h070a16b46b4d4144f79bdd9dd04a287c};
    vecs[2] = '{nblk: 3, data: {B0, B1, 128'h30c81c46a35ce4110123456789abcdef, 128'h0},
                nbytes: 5'd8, gap: 2, exp_tag: 128'hdfa66747de9ae63030ca32611497c827};
    vecs[3] = '{nblk: 4, data: {B0, B1, B2, B3},
                nbytes: 5'd16, gap: 0, exp_tag: 128'h51f0bebf7e3b9d92fc49741779363cfe};

    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_ctrl", {124'h0, msg_ready, tag_valid, busy, aes_ld}, 128'h0);
    chk("rst_tag", tag, 128'h0);
    chk("rst_aes_key", aes_key, 128'h0);
    chk("rst_aes_text", aes_text, 128'h0);
    chk("rst_k1", dut.k1_q, 128'h0);
    chk("rst_k2", dut.k2_q, 128'h0);
    chk("rst_x", dut.x_q, 128'h0);
    Rst = 1'b0;
    msg_valid = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_no_ready", {127'h0, msg_ready}, 128'h0);
    msg_valid = 1'b0;

    chk("model_L", aes_enc(KEY, 128'h0), 128'h7df76b0c1ab899b33e42f047b91b546f);

    // subkeys
    load_key(KEY, "key_ready_lat");
    chk("k1", dut.k1_q, 128'hfbeed618357133667c85e08f7236a8de);
    chk("k2", dut.k2_q, 128'hf7ddac306ae266ccf90bc11ee46d513b);

    // table: empty, one block, 40 bytes, 64 bytes back to back on one key
    prev_tag = '0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("v%0d_tag_hold", i), tag, prev_tag);
      send_msg(vecs[i], $sformatf("v%0d", i));
      prev_tag = vecs[i].exp_tag;
    end

    // abort during ENC of a 64-byte message
    msg_data = B0; msg_last = 1'b0; msg_bytes = 5'd16; msg_valid = 1'b1;
    wait_ready(w);
    @(negedge CLK);
    msg_valid = 1'b0;
    repeat (20) @(negedge CLK);
    chk("abort_busy", {127'h0, busy}, 128'h1);
    key_in = KEY; key_ld = 1'b1; t0 = cyc;
    @(negedge CLK);
    key_ld = 1'b0;
    saw_tag = 1'b0; w = 0;
    while (!msg_ready && w < LIM) begin
      saw_tag |= tag_valid;
      @(negedge CLK); w++;
    end
    chk("abort_ready_lat", 128'(cyc - t0), 128'(AES_LAT + 2));
    chk("abort_no_tag", {127'h0, saw_tag}, 128'h0);
    chk("abort_x_clear", dut.x_q, 128'h0);

    // key_ld collides with a block handshake
    msg_data = B0; msg_last = 1'b1; msg_bytes = 5'd16; msg_valid = 1'b1;
    key_ld = 1'b1; t0 = cyc;
    #1;
    chk("collide_ready_low", {127'h0, msg_ready}, 128'h0);
    @(negedge CLK);
    key_ld = 1'b0; msg_valid = 1'b0; msg_last = 1'b0;
    saw_tag = 1'b0; w = 0;
    while (!msg_ready && w < LIM) begin
      saw_tag |= tag_valid;
      @(negedge CLK); w++;
    end
    chk("collide_ready_lat", 128'(cyc - t0), 128'(AES_LAT + 2));
    chk("collide_no_tag", {127'h0, saw_tag}, 128'h0);
    send_msg(vecs[0], "post_abort_empty");

    // asynchronous reset during SUBKEY with random valid
    key_in = 128'h000102030405060708090a0b0c0d0e0f; key_ld = 1'b1;
    @(negedge CLK);
    key_ld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      msg_valid = 1'($urandom);
      @(negedge CLK);
    end
    #2 Rst = 1'b1;
    #1;
    chk("arst_ctrl", {124'h0, msg_ready, tag_valid, busy, aes_ld}, 128'h0);
    chk("arst_tag", tag, 128'h0);
    chk("arst_key_text", aes_key | aes_text, 128'h0);
    @(negedge CLK);
    Rst = 1'b0;
    saw_tag = 1'b0; saw_ready = 1'b0;
    for (int i = 0; i < 3*AES_LAT; i++) begin
      msg_valid = 1'($urandom);
      msg_last  = 1'($urandom);
      saw_tag   |= tag_valid;
      saw_ready |= msg_ready;
      @(negedge CLK);
    end
    msg_valid = 1'b0; msg_last = 1'b0;
    chk("arst_no_ready", {127'h0, saw_ready}, 128'h0);
    chk("arst_no_tag", {127'h0, saw_tag}, 128'h0);

    load_key(KEY, "rekey_ready_lat");
    send_msg(vecs[1], "recover_one_block");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
